// File: rtl/fpmul_pkg.sv
// fpmul_pkg -- shared constants for the single-precision FP multiplier
// control unit.
//
// Contents:
//   state_t             : control FSM state enumeration
//   EPS_ADD/BIAS/INC    : EP_SEL encodings for the exponent register mux
//   MPS_MP/SHL/INC/ONE  : MPH_SEL encodings for the mantissa-high register mux
package fpmul_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        CLASS = 4'd2,
        CHECK = 4'd3,
        BIAS  = 4'd4,
        NORM  = 4'd5,
        ROUND = 4'd6,
        RANGE = 4'd7,
        PACK  = 4'd8,
        DONE  = 4'd9
    } state_t;

    // Exponent register input select
    localparam logic [1:0] EPS_ADD  = 2'b00;  // EA + EB
    localparam logic [1:0] EPS_BIAS = 2'b10;  // EP - 127
    localparam logic [1:0] EPS_INC  = 2'b01;  // EP + 1

    // Mantissa-high register input select
    localparam logic [2:0] MPS_MP  = 3'b000;  // MP[47:24]
    localparam logic [2:0] MPS_SHL = 3'b001;  // shift left, MPL[23] enters
    localparam logic [2:0] MPS_INC = 3'b010;  // MPH + 1
    localparam logic [2:0] MPS_ONE = 3'b100;  // 0x800000 (rounding carry-out)

endpackage

// File: rtl/fpmul_cu.sv
// fpmul_cu -- control unit for the single-precision FP multiplier datapath.
//
// Sequences operand load, special-case detection, exponent add/bias,
// one-step normalisation, rounding, range check and result pack, and
// presents a start/busy/done handshake.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   start, busy, done   : system handshake (done is a one-cycle pulse)
//   Op_NaN/Op_Inf/Op_Zero, MPH23, Round, Carry, UFlow, OFlow
//                       : datapath status inputs
//   *_LD/*_RST/*_SET/*_SEL
//                       : datapath register controls, decoded
//                         combinationally from the state register and
//                         status inputs; all zero while rst is high
//
// Build option:
//   FPMUL_CU_BACK2BACK_EN : when defined, a start seen in DONE is accepted
//                           and the unit goes straight to LOAD (busy stays
//                           high). When undefined, DONE always returns to
//                           IDLE and start there is ignored.
module fpmul_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       Op_NaN,
    input  logic       Op_Inf,
    input  logic       Op_Zero,
    input  logic       MPH23,
    input  logic       Round,
    input  logic       Carry,
    input  logic       UFlow,
    input  logic       OFlow,
    output logic       SA_LD,
    output logic       SB_LD,
    output logic       EA_LD,
    output logic       EB_LD,
    output logic       MA_LD,
    output logic       MB_LD,
    output logic       SP_LD,
    output logic       EP_RST,
    output logic       EP_SET,
    output logic       EP_LD,
    output logic [1:0] EP_SEL,
    output logic       MPH_RST,
    output logic       MPH_SET,
    output logic       MPH_LD,
    output logic [2:0] MPH_SEL,
    output logic       MPL_SEL,
    output logic       MPL_LD,
    output logic       NAN_RST,
    output logic       NAN_LD,
    output logic       INF_RST,
    output logic       INF_LD,
    output logic       ZF_RST,
    output logic       ZF_LD,
    output logic       UF_RST,
    output logic       UF_LD,
    output logic       OF_RST,
    output logic       OF_LD,
    output logic       P_RST,
    output logic       P_LD
);

    import fpmul_pkg::*;

    state_t state_q;
    state_t state_d;
    logic   accept;     // a new multiply is being accepted this cycle

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        SA_LD   = 1'b0;
        SB_LD   = 1'b0;
        EA_LD   = 1'b0;
        EB_LD   = 1'b0;
        MA_LD   = 1'b0;
        MB_LD   = 1'b0;
        SP_LD   = 1'b0;
        EP_RST  = 1'b0;
        EP_SET  = 1'b0;
        EP_LD   = 1'b0;
        EP_SEL  = EPS_ADD;
        MPH_RST = 1'b0;
        MPH_SET = 1'b0;
        MPH_LD  = 1'b0;
        MPH_SEL = MPS_MP;
        MPL_SEL = 1'b0;
        MPL_LD  = 1'b0;
        NAN_RST = 1'b0;
        NAN_LD  = 1'b0;
        INF_RST = 1'b0;
        INF_LD  = 1'b0;
        ZF_RST  = 1'b0;
        ZF_LD   = 1'b0;
        UF_RST  = 1'b0;
        UF_LD   = 1'b0;
        OF_RST  = 1'b0;
        OF_LD   = 1'b0;
        P_RST   = 1'b0;
        P_LD    = 1'b0;

        // Strobes are suppressed while reset is held so that an abandoned
        // operation can never leak a P_LD during the reset cycle.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        accept  = 1'b1;
                        state_d = LOAD;
                    end
                end
                LOAD:  state_d = CLASS;   // classification flops sample
                CLASS: state_d = CHECK;   // Op_* valid from here on
                CHECK: begin
                    SP_LD = 1'b1;
                    if (Op_NaN) begin
                        EP_SET  = 1'b1;
                        MPH_SET = 1'b1;
                        NAN_LD  = 1'b1;
                        state_d = PACK;
                    end else if (Op_Inf) begin
                        EP_SET  = 1'b1;
                        MPH_RST = 1'b1;
                        INF_LD  = 1'b1;
                        state_d = PACK;
                    end else if (Op_Zero) begin
                        EP_RST  = 1'b1;
                        MPH_RST = 1'b1;
                        ZF_LD   = 1'b1;
                        state_d = PACK;
                    end else begin
                        EP_LD   = 1'b1;
                        EP_SEL  = EPS_ADD;
                        MPH_LD  = 1'b1;
                        MPH_SEL = MPS_MP;
                        MPL_LD  = 1'b1;
                        MPL_SEL = 1'b0;
                        state_d = BIAS;
                    end
                end
                BIAS: begin
                    EP_LD   = 1'b1;
                    EP_SEL  = EPS_BIAS;
                    state_d = NORM;
                end
                NORM: begin
                    // The product of two 1.x mantissas is in [1,4), so a
                    // single step of either kind is always sufficient.
                    if (MPH23) begin
                        EP_LD  = 1'b1;
                        EP_SEL = EPS_INC;
                    end else begin
                        MPH_LD  = 1'b1;
                        MPH_SEL = MPS_SHL;
                        MPL_LD  = 1'b1;
                        MPL_SEL = 1'b1;
                    end
                    state_d = ROUND;
                end
                ROUND: begin
                    if (Round) begin
                        MPH_LD = 1'b1;
                        if (Carry) begin
                            // Increment overflows the mantissa: renormalise
                            // to 1.0 and bump the exponent in one cycle.
                            MPH_SEL = MPS_ONE;
                            EP_LD   = 1'b1;
                            EP_SEL  = EPS_INC;
                        end else begin
                            MPH_SEL = MPS_INC;
                        end
                    end
                    state_d = RANGE;
                end
                RANGE: begin
                    if (UFlow) begin
                        UF_LD   = 1'b1;
                        EP_RST  = 1'b1;
                        MPH_RST = 1'b1;
                    end else if (OFlow) begin
                        OF_LD   = 1'b1;
                        EP_SET  = 1'b1;
                        MPH_RST = 1'b1;
                    end
                    state_d = PACK;
                end
                PACK: begin
                    P_LD    = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
`ifdef FPMUL_CU_BACK2BACK_EN
                    if (start) begin
                        accept  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase

            if (accept) begin
                SA_LD   = 1'b1;
                SB_LD   = 1'b1;
                EA_LD   = 1'b1;
                EB_LD   = 1'b1;
                MA_LD   = 1'b1;
                MB_LD   = 1'b1;
                NAN_RST = 1'b1;
                INF_RST = 1'b1;
                ZF_RST  = 1'b1;
                UF_RST  = 1'b1;
                OF_RST  = 1'b1;
                P_RST   = 1'b1;
            end
        end
    end

    assign busy = !rst && (state_q != IDLE);
    assign done = !rst && (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_fpmul_cu.sv
// tb_fpmul_cu -- self-checking bench for fpmul_cu.
//
// A behavioural datapath around the control unit reacts to its strobes and
// supplies the status flags. Each issued multiply pushes the expected
// product, flag set and latency (from a plain-arithmetic reference multiply)
// into a scoreboard queue; a monitor pops and compares whenever done pulses.
module tb_fpmul_cu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    logic Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow;
    logic SA_LD, SB_LD, EA_LD, EB_LD, MA_LD, MB_LD, SP_LD;
    logic EP_RST, EP_SET, EP_LD;
    logic [1:0] EP_SEL;
    logic MPH_RST, MPH_SET, MPH_LD;
    logic [2:0] MPH_SEL;
    logic MPL_SEL, MPL_LD;
    logic NAN_RST, NAN_LD, INF_RST, INF_LD, ZF_RST, ZF_LD;
    logic UF_RST, UF_LD, OF_RST, OF_LD, P_RST, P_LD;

    always #5 clk = ~clk;

    fpmul_cu dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .Op_NaN(Op_NaN), .Op_Inf(Op_Inf), .Op_Zero(Op_Zero), .MPH23(MPH23),
        .Round(Round), .Carry(Carry), .UFlow(UFlow), .OFlow(OFlow),
        .SA_LD(SA_LD), .SB_LD(SB_LD), .EA_LD(EA_LD), .EB_LD(EB_LD),
        .MA_LD(MA_LD), .MB_LD(MB_LD), .SP_LD(SP_LD),
        .EP_RST(EP_RST), .EP_SET(EP_SET), .EP_LD(EP_LD), .EP_SEL(EP_SEL),
        .MPH_RST(MPH_RST), .MPH_SET(MPH_SET), .MPH_LD(MPH_LD), .MPH_SEL(MPH_SEL),
        .MPL_SEL(MPL_SEL), .MPL_LD(MPL_LD),
        .NAN_RST(NAN_RST), .NAN_LD(NAN_LD), .INF_RST(INF_RST), .INF_LD(INF_LD),
        .ZF_RST(ZF_RST), .ZF_LD(ZF_LD), .UF_RST(UF_RST), .UF_LD(UF_LD),
        .OF_RST(OF_RST), .OF_LD(OF_LD), .P_RST(P_RST), .P_LD(P_LD)
    );

    logic [31:0] ctrl_vec;
    assign ctrl_vec = {SA_LD, SB_LD, EA_LD, EB_LD, MA_LD, MB_LD, SP_LD,
                       EP_RST, EP_SET, EP_LD, EP_SEL, MPH_RST, MPH_SET, MPH_LD,
                       MPH_SEL, MPL_SEL, MPL_LD, NAN_RST, NAN_LD, INF_RST,
                       INF_LD, ZF_RST, ZF_LD, UF_RST, UF_LD, OF_RST, OF_LD,
                       P_RST, P_LD};

    // ---------------- behavioural datapath ----------------
    logic [31:0] a_in = '0, b_in = '0;
    logic        sa = 0, sb = 0, sp = 0;
    logic [7:0]  ea = '0, eb = '0;
    logic [23:0] ma = '0, mb = '0, mph = '0, mpl = '0;
    logic [9:0]  ep = '0;
    logic [31:0] p_reg = '0;
    logic nan_f = 0, inf_f = 0, zf_f = 0, uf_f = 0, of_f = 0;
    logic op_nan_q = 0, op_inf_q = 0, op_zero_q = 0;
    logic force_round = 0, force_carry = 0, force_uflow = 0, force_oflow = 0;
    logic [47:0] mp;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign mp     = {24'b0, ma} * {24'b0, mb};
    assign a_nan  = (ea == 8'hFF) && (ma[22:0] != 23'h0);
    assign b_nan  = (eb == 8'hFF) && (mb[22:0] != 23'h0);
    assign a_inf  = (ea == 8'hFF) && (ma[22:0] == 23'h0);
    assign b_inf  = (eb == 8'hFF) && (mb[22:0] == 23'h0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    assign Op_NaN  = op_nan_q;
    assign Op_Inf  = op_inf_q;
    assign Op_Zero = op_zero_q;
    assign MPH23   = mph[23];
    assign Round   = mpl[23] | force_round;
    assign Carry   = (&mph) | force_carry;
    assign UFlow   = ($signed(ep) <= 10'sd0) | force_uflow;
    assign OFlow   = (!ep[9] && (ep >= 10'd255)) | force_oflow;

    always @(posedge clk) begin
        if (SA_LD) sa <= a_in[31];
        if (SB_LD) sb <= b_in[31];
        if (EA_LD) ea <= a_in[30:23];
        if (EB_LD) eb <= b_in[30:23];
        if (MA_LD) ma <= {|a_in[30:23], a_in[22:0]};
        if (MB_LD) mb <= {|b_in[30:23], b_in[22:0]};
        op_nan_q  <= a_nan | b_nan | ((a_inf | b_inf) & (a_zero | b_zero));
        op_inf_q  <= a_inf | b_inf;
        op_zero_q <= a_zero | b_zero;
        if (SP_LD) sp <= sa ^ sb;
        if (EP_RST)      ep <= 10'd0;
        else if (EP_SET) ep <= 10'd255;
        else if (EP_LD) begin
            case (EP_SEL)
                2'b00:   ep <= {2'b0, ea} + {2'b0, eb};
                2'b10:   ep <= ep - 10'd127;
                2'b01:   ep <= ep + 10'd1;
                default: ep <= 10'h3FF;
            endcase
        end
        if (MPH_RST)      mph <= 24'h0;
        else if (MPH_SET) mph <= 24'hC00000;
        else if (MPH_LD) begin
            case (MPH_SEL)
                3'b000:  mph <= mp[47:24];
                3'b001:  mph <= {mph[22:0], mpl[23]};
                3'b010:  mph <= mph + 24'd1;
                3'b100:  mph <= 24'h800000;
                default: mph <= 24'hDEAD00;
            endcase
        end
        if (MPL_LD) mpl <= MPL_SEL ? {mpl[22:0], 1'b0} : mp[23:0];
        if (NAN_RST) nan_f <= 0; else if (NAN_LD) nan_f <= 1;
        if (INF_RST) inf_f <= 0; else if (INF_LD) inf_f <= 1;
        if (ZF_RST)  zf_f  <= 0; else if (ZF_LD)  zf_f  <= 1;
        if (UF_RST)  uf_f  <= 0; else if (UF_LD)  uf_f  <= 1;
        if (OF_RST)  of_f  <= 0; else if (OF_LD)  of_f  <= 1;
        if (P_RST)     p_reg <= 32'h0;
        else if (P_LD) p_reg <= {sp, ep[7:0], mph[22:0]};
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [4:0]  fl;    // {nan, inf, zero, uflow, oflow}
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // IEEE-like single multiply: denormals count as zero, Inf*0 is NaN,
    // round-half-up on the first discarded bit, flush-to-zero on underflow.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p, output logic [4:0] fl,
                                    output int lat);
        logic s;
        int ea_i, eb_i, e;
        logic [47:0] prod;
        logic [24:0] m;
        logic rb;
        bit an, bn, ai, bi, az, bz;
        s    = a[31] ^ b[31];
        ea_i = int'(a[30:23]);
        eb_i = int'(b[30:23]);
        an = (ea_i == 255) && (a[22:0] != 0);
        bn = (eb_i == 255) && (b[22:0] != 0);
        ai = (ea_i == 255) && (a[22:0] == 0);
        bi = (eb_i == 255) && (b[22:0] == 0);
        az = (ea_i == 0);
        bz = (eb_i == 0);
        lat = 5;
        if (an || bn || ((ai || bi) && (az || bz))) begin
            p = {s, 8'hFF, 23'h400000}; fl = 5'b10000;
        end else if (ai || bi) begin
            p = {s, 8'hFF, 23'h0};      fl = 5'b01000;
        end else if (az || bz) begin
            p = {s, 31'h0};             fl = 5'b00100;
        end else begin
            lat  = 9;
            fl   = 5'b00000;
            prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
            e    = ea_i + eb_i - 127;
            if (prod[47]) begin
                e  = e + 1;
                m  = {1'b0, prod[47:24]};
                rb = prod[23];
            end else begin
                m  = {1'b0, prod[46:23]};
                rb = prod[22];
            end
            m = m + 25'(rb);
            if (m[24]) begin
                m = 25'h0800000;
                e = e + 1;
            end
            if (e <= 0) begin
                p = {s, 31'h0}; fl = 5'b00010;
            end else if (e >= 255) begin
                p = {s, 8'hFF, 23'h0}; fl = 5'b00001;
            end else begin
                p = {s, e[7:0], m[22:0]};
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest outstanding entry.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("product", p_reg, e.p);
                chk("flags", {27'b0, nan_f, inf_f, zf_f, uf_f, of_f}, {27'b0, e.fl});
                chk("latency", cyc - e.start_cyc, e.lat);
                $display("[TB] tx a=%08h b=%08h p=%08h flags=%05b lat=%0d",
                         e.a, e.b, p_reg, {nan_f, inf_f, zf_f, uf_f, of_f}, cyc - e.start_cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Returns during cycle 1 (start was sampled at edge 0).
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input bit use_ref, input logic [31:0] xp, input logic [4:0] xf);
        exp_t e;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        e.a = a;
        e.b = b;
        if (use_ref) begin
            ref_mul(a, b, e.p, e.fl, e.lat);
        end else begin
            e.p = xp; e.fl = xf; e.lat = 9;
        end
        e.start_cyc = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done (bounded), toggling start as noise while the unit is
    // busy, then steps one cycle past DONE.
    task automatic finish_tx(input bit noise);
        int  n = 0;
        bit  seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (done) begin
                start = 1'b0;
                seen  = 1;
            end else begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] rand_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        k = $urandom_range(0, 9);
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1: begin
                e = 8'hFF;
                if ($urandom_range(0, 1) == 1) f = 23'h0;
            end
            2, 3:    e = 8'($urandom);
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", ctrl_vec, 32'h0);
        chk("rst_busy_done", {30'b0, busy, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy_done", {30'b0, busy, done}, 32'h0);
        chk("idle_ctrl", ctrl_vec, 32'h0);

        // 1.5 x 2.0: shift path, no rounding
        issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000);
        chk("busy_in_load", 32'(busy), 32'd1);
        finish_tx(1'b1);

        // NaN operand: special path, NaN strobes in cycle 3
        issue(32'h7FC00000, 32'h3F800000, 1'b1, 32'h0, 5'b0);
        repeat (2) @(negedge clk);
        chk("nan_check_strobes", {28'b0, NAN_LD, EP_SET, MPH_SET, SP_LD}, 32'hF);
        chk("nan_check_others", {29'b0, INF_LD, ZF_LD, EP_LD}, 32'h0);
        finish_tx(1'b0);

        // Inf x 0: NaN takes priority
        issue(32'h7F800000, 32'h00000000, 1'b1, 32'h0, 5'b0);
        repeat (2) @(negedge clk);
        chk("inf0_check_strobes", {29'b0, NAN_LD, INF_LD, ZF_LD}, 32'h4);
        finish_tx(1'b0);

        // Forced Round & Carry in ROUND (cycle 6)
        force_round = 1'b1;
        force_carry = 1'b1;
        issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h40800000, 5'b00000);
        repeat (5) @(negedge clk);
        chk("round_carry_strobes", {25'b0, MPH_LD, EP_LD, MPH_SEL, EP_SEL}, {25'b0, 1'b1, 1'b1, 3'b100, 2'b01});
        finish_tx(1'b0);
        force_round = 1'b0;
        force_carry = 1'b0;

        // Forced OFlow in RANGE (cycle 7), then P_LD in cycle 8
        force_oflow = 1'b1;
        issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h7F800000, 5'b00001);
        repeat (6) @(negedge clk);
        chk("oflow_strobes", {27'b0, OF_LD, EP_SET, MPH_RST, UF_LD, P_LD}, 32'h1C);
        @(negedge clk);
        chk("oflow_then_pld", 32'(P_LD), 32'd1);
        finish_tx(1'b0);

        // UFlow and OFlow together: UFlow wins
        force_uflow = 1'b1;
        issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h00000000, 5'b00010);
        repeat (6) @(negedge clk);
        chk("uflow_prio_strobes", {28'b0, UF_LD, OF_LD, EP_RST, MPH_RST}, 32'hB);
        finish_tx(1'b0);
        force_uflow = 1'b0;
        force_oflow = 1'b0;

        // Randomised operands against the reference multiply
        for (int i = 0; i < 40; i++) begin
            issue(rand_op(), rand_op(), 1'b1, 32'h0, 5'b0);
            finish_tx(1'b1);
        end

        // Reset in NORM (cycle 5): abandon, no P_LD, no done
        @(negedge clk);
        a_in  = 32'h3FC00000;
        b_in  = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", ctrl_vec, 32'h0);
        chk("rst_mid_busy_done", {30'b0, busy, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_idle", {30'b0, busy, done}, 32'h0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (P_LD || done || busy) bad++;
        end
        chk("abort_clean", 32'(bad), 32'd0);

        // start presented while in DONE
        issue(32'h3FC00000, 32'h40000000, 1'b1, 32'h0, 5'b0);
        repeat (8) @(negedge clk);
        a_in  = 32'h40400000;
        b_in  = 32'h40400000;
        start = 1'b1;
`ifdef FPMUL_CU_BACK2BACK_EN
        begin
            exp_t e2;
            e2.a = a_in;
            e2.b = b_in;
            ref_mul(a_in, b_in, e2.p, e2.fl, e2.lat);
            e2.start_cyc = cyc;
            sb_q.push_back(e2);
        end
        #1;
        chk("b2b_accept_strobes", {26'b0, SA_LD, MB_LD, P_RST, NAN_RST, busy, done}, 32'h3F);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_held", 32'(busy), 32'd1);
        finish_tx(1'b0);
`else
        #1;
        chk("done_start_no_strobes", ctrl_vec, 32'h0);
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored", {30'b0, busy, done}, 32'h0);
        repeat (12) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
